// File: rtl/dsp48_mac_pipe_if.sv
// Operand, control and result bundle for the dsp48_mac_pipe pre-add/multiply/accumulate slice.
interface dsp48_mac_pipe_if #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48
);
  logic                              CE;
  logic                              IN_VALID;
  logic signed [A_WIDTH-1:0]         A;
  logic signed [B_WIDTH-1:0]         B;
  logic signed [B_WIDTH-1:0]         D;
  logic signed [P_WIDTH-1:0]         C;
  logic signed [P_WIDTH-1:0]         PCIN;
  logic                              CARRYIN;
  logic [4:0]                        OPMODE;
  logic                              OUT_VALID;
  logic signed [P_WIDTH-1:0]         P;
  logic signed [P_WIDTH-1:0]         PCOUT;
  logic signed [B_WIDTH-1:0]         BCOUT;
  logic signed [A_WIDTH+B_WIDTH-1:0] M;
  logic                              CARRYOUT;
  logic                              OVERFLOW;
  logic                              PATTERN_DETECT;

  modport master (
    output CE, IN_VALID, A, B, D, C, PCIN, CARRYIN, OPMODE,
    input  OUT_VALID, P, PCOUT, BCOUT, M, CARRYOUT, OVERFLOW, PATTERN_DETECT
  );

  modport slave (
    input  CE, IN_VALID, A, B, D, C, PCIN, CARRYIN, OPMODE,
    output OUT_VALID, P, PCOUT, BCOUT, M, CARRYOUT, OVERFLOW, PATTERN_DETECT
  );
endinterface

// File: rtl/dsp48_mac_pipe.sv
// Three-stage DSP slice: operand capture, pre-add + signed multiply, post-add/accumulate
// with carry, overflow (wrap or saturate) and pattern detect.
module dsp48_mac_pipe #(
  parameter int               A_WIDTH  = 18,
  parameter int               B_WIDTH  = 18,
  parameter int               P_WIDTH  = 48,
  parameter int               SATURATE = 0,
  parameter logic [P_WIDTH-1:0] PATTERN = '0,
  parameter logic [P_WIDTH-1:0] MASK    = '0
) (
  input  logic             CLK,
  input  logic             RST,
  dsp48_mac_pipe_if.slave  bus
);

  localparam int M_W = A_WIDTH + B_WIDTH;
  localparam int X_W = P_WIDTH + 2;

  // Pre-adder: B, D+B or D-B, wrapped to the B operand width.
  function automatic logic signed [B_WIDTH-1:0] preadd_fn(input logic [1:0] mode,
                                                          input logic signed [B_WIDTH-1:0] d,
                                                          input logic signed [B_WIDTH-1:0] b);
    if (!mode[0])     return b;
    else if (mode[1]) return d - b;
    else              return d + b;
  endfunction

  // Result no longer fits P_WIDTH signed bits when the top three bits disagree.
  function automatic logic ovf_fn(input logic signed [X_W-1:0] full);
    return !((full[X_W-1:P_WIDTH-1] == '0) || (full[X_W-1:P_WIDTH-1] == '1));
  endfunction

  // Clamp toward the true sign of the wide result.
  function automatic logic signed [P_WIDTH-1:0] sat_fn(input logic signed [X_W-1:0] full);
    logic signed [P_WIDTH-1:0] r;
    r = full[X_W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
    return r;
  endfunction

  logic signed [A_WIDTH-1:0] a_p1_d, a_p1_q;
  logic signed [B_WIDTH-1:0] b_p1_d, b_p1_q, d_p1_d, d_p1_q;
  logic signed [P_WIDTH-1:0] c_p1_d, c_p1_q, pcin_p1_d, pcin_p1_q;
  logic                      cin_p1_d, cin_p1_q, vld_p1_d, vld_p1_q;
  logic [4:0]                op_p1_d, op_p1_q;

  logic signed [B_WIDTH-1:0] b_p2_d, b_p2_q;
  logic signed [M_W-1:0]     m_p2_d, m_p2_q;
  logic signed [P_WIDTH-1:0] c_p2_d, c_p2_q, pcin_p2_d, pcin_p2_q;
  logic                      cin_p2_d, cin_p2_q, vld_p2_d, vld_p2_q;
  logic [4:0]                op_p2_d, op_p2_q;

  logic signed [P_WIDTH-1:0] p_p3_d, p_p3_q;
  logic                      co_p3_d, co_p3_q, ovf_p3_d, ovf_p3_q, pd_p3_d, pd_p3_q;
  logic                      vld_p3_d, vld_p3_q;

  logic signed [B_WIDTH-1:0] bpre;
  logic signed [P_WIDTH-1:0] z, mx, p_nxt;
  logic signed [X_W-1:0]     cin_x, full;
  logic [P_WIDTH:0]          cin_u, uadd;
  logic                      ovf_w;

  // Stage 1 capture and stage 2 pre-add/multiply; everything holds while CE is low.
  always_comb begin
    a_p1_d    = a_p1_q;    b_p1_d   = b_p1_q;   d_p1_d   = d_p1_q;
    c_p1_d    = c_p1_q;    pcin_p1_d = pcin_p1_q;
    cin_p1_d  = cin_p1_q;  op_p1_d  = op_p1_q;  vld_p1_d = vld_p1_q;
    b_p2_d    = b_p2_q;    m_p2_d   = m_p2_q;   c_p2_d   = c_p2_q;
    pcin_p2_d = pcin_p2_q; cin_p2_d = cin_p2_q; op_p2_d  = op_p2_q;  vld_p2_d = vld_p2_q;
    bpre      = preadd_fn(op_p1_q[1:0], d_p1_q, b_p1_q);
    if (bus.CE) begin
      a_p1_d    = bus.A;       b_p1_d   = bus.B;       d_p1_d   = bus.D;
      c_p1_d    = bus.C;       pcin_p1_d = bus.PCIN;
      cin_p1_d  = bus.CARRYIN; op_p1_d  = bus.OPMODE;  vld_p1_d = bus.IN_VALID;
      b_p2_d    = bpre;
      m_p2_d    = M_W'(a_p1_q) * M_W'(bpre);
      c_p2_d    = c_p1_q;      pcin_p2_d = pcin_p1_q;
      cin_p2_d  = cin_p1_q;    op_p2_d  = op_p1_q;    vld_p2_d = vld_p1_q;
    end
  end

  // Stage 3 post-adder: Z +/- (M + CIN); result flags only move with a valid sample.
  always_comb begin
    case (op_p2_q[3:2])
      2'b01:   z = p_p3_q;
      2'b10:   z = c_p2_q;
      2'b11:   z = pcin_p2_q;
      default: z = '0;
    endcase
    mx    = P_WIDTH'(m_p2_q);
    cin_x = '0;
    cin_x[0] = cin_p2_q;
    cin_u = '0;
    cin_u[0] = cin_p2_q;
    if (op_p2_q[4]) begin
      full = X_W'(z) - (X_W'(mx) + cin_x);
      uadd = {1'b0, z} - {1'b0, mx} - cin_u;
    end else begin
      full = X_W'(z) + (X_W'(mx) + cin_x);
      uadd = {1'b0, z} + {1'b0, mx} + cin_u;
    end
    ovf_w = ovf_fn(full);
    p_nxt = ((SATURATE != 0) && ovf_w) ? sat_fn(full) : full[P_WIDTH-1:0];
    p_p3_d   = p_p3_q;
    co_p3_d  = co_p3_q;
    ovf_p3_d = ovf_p3_q;
    pd_p3_d  = pd_p3_q;
    vld_p3_d = vld_p3_q;
    if (bus.CE) begin
      vld_p3_d = vld_p2_q;
      if (vld_p2_q) begin
        p_p3_d   = p_nxt;
        co_p3_d  = uadd[P_WIDTH];
        ovf_p3_d = ovf_w;
        pd_p3_d  = ((p_nxt ^ PATTERN) & ~MASK) == '0;
      end
    end
  end

  // All pipeline state clears on reset, which takes priority over CE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_p1_q <= '0; b_p1_q <= '0; d_p1_q <= '0; c_p1_q <= '0; pcin_p1_q <= '0;
      cin_p1_q <= 1'b0; op_p1_q <= '0; vld_p1_q <= 1'b0;
      b_p2_q <= '0; m_p2_q <= '0; c_p2_q <= '0; pcin_p2_q <= '0;
      cin_p2_q <= 1'b0; op_p2_q <= '0; vld_p2_q <= 1'b0;
      p_p3_q <= '0; co_p3_q <= 1'b0; ovf_p3_q <= 1'b0; pd_p3_q <= 1'b0; vld_p3_q <= 1'b0;
    end else begin
      a_p1_q <= a_p1_d; b_p1_q <= b_p1_d; d_p1_q <= d_p1_d; c_p1_q <= c_p1_d;
      pcin_p1_q <= pcin_p1_d; cin_p1_q <= cin_p1_d; op_p1_q <= op_p1_d; vld_p1_q <= vld_p1_d;
      b_p2_q <= b_p2_d; m_p2_q <= m_p2_d; c_p2_q <= c_p2_d; pcin_p2_q <= pcin_p2_d;
      cin_p2_q <= cin_p2_d; op_p2_q <= op_p2_d; vld_p2_q <= vld_p2_d;
      p_p3_q <= p_p3_d; co_p3_q <= co_p3_d; ovf_p3_q <= ovf_p3_d; pd_p3_q <= pd_p3_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  assign bus.OUT_VALID      = vld_p3_q;
  assign bus.P              = p_p3_q;
  assign bus.PCOUT          = p_p3_q;
  assign bus.BCOUT          = b_p2_q;
  assign bus.M              = m_p2_q;
  assign bus.CARRYOUT       = co_p3_q;
  assign bus.OVERFLOW       = ovf_p3_q;
  assign bus.PATTERN_DETECT = pd_p3_q;

endmodule
